// File: rtl/csr_counter_file_if.sv
// CSR operation encoding and the CSR access bundle (enable/op/address/data, read data, illegal flag)
// shared by the execute stage and csr_counter_file.
package HighLevelControl;
  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csrOp;
endpackage

interface csr_counter_file_if #(
  parameter int XLEN = 64
);
  logic                   CSREn;
  HighLevelControl::csrOp CSROp;
  logic [11:0]            CSRAdr;
  logic [XLEN-1:0]        WriteData;
  logic [XLEN-1:0]        ReadData;
  logic                   IllegalAccess;

  modport master (
    output CSREn, CSROp, CSRAdr, WriteData,
    input  ReadData, IllegalAccess
  );

  modport slave (
    input  CSREn, CSROp, CSRAdr, WriteData,
    output ReadData, IllegalAccess
  );
endinterface

// File: rtl/csr_counter_file.sv
// Machine counter bank: 64-bit mcycle, minstret, mhpmcounter3.. plus mcountinhibit, CSR-accessed.
// Define CSR_USER_SHADOW_EN to decode the read-only user shadows at 0xCxx.
module csr_counter_file
  import HighLevelControl::*;
#(
  parameter int XLEN      = 64,
  parameter int NUM_HPM   = 4,
  parameter int INC_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  csr_counter_file_if.slave     bus,
  input  logic [INC_WIDTH-1:0]  RetireCount,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)*INC_WIDTH-1:0] HpmEvents
);

  // Slot 0 = mcycle, slot 1 = minstret, slot 2+i = mhpmcounter(3+i); CSR index 1 has no storage.
  localparam int NS = 2 + NUM_HPM;
  localparam logic [63:0] INH_MASK = 64'h5 | (((64'd1 << NUM_HPM) - 64'd1) << 3);

  function automatic logic [63:0] apply_op(input csrOp op, input logic [63:0] old_v,
                                           input logic [63:0] wd_v);
    case (op)
      CSR_WRITE: apply_op = wd_v;
      CSR_SET:   apply_op = old_v | wd_v;
      CSR_CLEAR: apply_op = old_v & ~wd_v;
      default:   apply_op = old_v;
    endcase
  endfunction

  logic [63:0]   cnt_r [NS];
  logic [63:0]   inh_r;
  logic [63:0]   inc_s [NS];
  logic [NS-1:0] run_s;

  logic [11:0]   adr_s;
  logic [4:0]    idx_s;
  logic [4:0]    slot_s;
  logic          hi_s;
  logic          is_inh_s;
  logic          is_cnt_s;
  logic          ro_s;
  logic          idx_ok_s;
  logic          legal_s;
  logic          wr_s;
  logic [63:0]   old_cnt_s;
  logic [63:0]   old_half_s;
  logic [63:0]   wd_s;
  logic [63:0]   new_half_s;
  logic [63:0]   new_cnt_s;
  logic [63:0]   inh_new_s;
  logic [XLEN-1:0] read_s;

  // Address decode and legality of the current access
  always_comb begin
    adr_s    = bus.CSRAdr;
    idx_s    = adr_s[4:0];
    hi_s     = adr_s[7];
    is_inh_s = (adr_s == 12'h320);
`ifdef CSR_USER_SHADOW_EN
    ro_s     = (adr_s[11:8] == 4'hC);
`else
    ro_s     = 1'b0;
`endif
    if (idx_s == 5'd0) begin
      slot_s   = 5'd0;
      idx_ok_s = 1'b1;
    end else if (idx_s == 5'd2) begin
      slot_s   = 5'd1;
      idx_ok_s = 1'b1;
    end else if (idx_s >= 5'd3 && int'(idx_s) < 3 + NUM_HPM) begin
      slot_s   = idx_s - 5'd1;
      idx_ok_s = 1'b1;
    end else begin
      slot_s   = 5'd0;
      idx_ok_s = 1'b0;
    end
    // High-half addresses only exist when a counter spans two CSRs.
    is_cnt_s = ((adr_s[11:8] == 4'hB) || ro_s) && (adr_s[6:5] == 2'b00) && idx_ok_s
               && (!hi_s || XLEN == 32);
    legal_s  = is_inh_s || (is_cnt_s && !(ro_s && bus.CSROp != CSR_READ));
    wr_s     = bus.CSREn && legal_s && (bus.CSROp != CSR_READ);
  end

  // Half selection, read-modify-write values and read mux
  always_comb begin
    old_cnt_s = 64'd0;
    for (int k = 0; k < NS; k++) begin
      old_cnt_s = (slot_s == 5'(k)) ? cnt_r[k] : old_cnt_s;
    end
    if (XLEN == 64) begin
      old_half_s = old_cnt_s;
    end else if (hi_s) begin
      old_half_s = {32'd0, old_cnt_s[63:32]};
    end else begin
      old_half_s = {32'd0, old_cnt_s[31:0]};
    end
    wd_s       = 64'(bus.WriteData);
    new_half_s = apply_op(bus.CSROp, old_half_s, wd_s);
    if (XLEN == 64) begin
      new_cnt_s = new_half_s;
    end else if (hi_s) begin
      new_cnt_s = {new_half_s[31:0], old_cnt_s[31:0]};
    end else begin
      new_cnt_s = {old_cnt_s[63:32], new_half_s[31:0]};
    end
    inh_new_s = apply_op(bus.CSROp, inh_r, wd_s) & INH_MASK;
    if (!bus.CSREn || !legal_s) begin
      read_s = '0;
    end else if (is_inh_s) begin
      read_s = inh_r[XLEN-1:0];
    end else begin
      read_s = old_half_s[XLEN-1:0];
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_inc
    localparam int INH_BIT = (k == 0) ? 0 : k + 1;
    if (k == 0) begin : g_cycle
      assign inc_s[k] = 64'd1;
    end else if (k == 1) begin : g_instret
      assign inc_s[k] = 64'(RetireCount);
    end else begin : g_hpm
      assign inc_s[k] = 64'(HpmEvents[(k-2)*INC_WIDTH +: INC_WIDTH]);
    end
    assign run_s[k] = ~inh_r[INH_BIT];
  end

  // Counter and inhibit state; a CSR update replaces that counter's increment for the cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NS; k++) begin
        cnt_r[k] <= 64'd0;
      end
      inh_r <= 64'd0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (wr_s && is_cnt_s && slot_s == 5'(k)) begin
          cnt_r[k] <= new_cnt_s;
        end else if (run_s[k]) begin
          cnt_r[k] <= cnt_r[k] + inc_s[k];
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
      if (wr_s && is_inh_s) begin
        inh_r <= inh_new_s;
      end else begin
        inh_r <= inh_r;
      end
    end
  end

  assign bus.ReadData      = read_s;
  assign bus.IllegalAccess = bus.CSREn && !legal_s;

endmodule

// File: tb/tb_csr_counter_file.sv
// Scoreboard bench: one XLEN=64 and one XLEN=32 instance share stimulus; a spec-level model
// predicts ReadData/IllegalAccess per cycle and a negedge monitor compares.
module tb_csr_counter_file;
  import HighLevelControl::*;

  localparam int NH = 4;
  localparam int IW = 2;
  localparam logic [63:0] INH_MASK = 64'h7D;  // bits 0, 2, 3..6
`ifdef CSR_USER_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] rd;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [IW-1:0]    ret;
  logic [NH*IW-1:0] hpm;

  csr_counter_file_if #(.XLEN(64)) b64 ();
  csr_counter_file_if #(.XLEN(32)) b32 ();

  csr_counter_file #(.XLEN(64), .NUM_HPM(NH), .INC_WIDTH(IW)) dut64 (
    .clk(clk), .reset(reset), .bus(b64.slave), .RetireCount(ret), .HpmEvents(hpm));
  csr_counter_file #(.XLEN(32), .NUM_HPM(NH), .INC_WIDTH(IW)) dut32 (
    .clk(clk), .reset(reset), .bus(b32.slave), .RetireCount(ret), .HpmEvents(hpm));

  always #5 clk = ~clk;

  exp_t q64[$];
  exp_t q32[$];
  logic [63:0] mcnt [2][32];
  logic [63:0] minh [2];
  int checks;
  int errors;
  bit running;

  function automatic logic [63:0] opf(int op, logic [63:0] o, logic [63:0] w);
    case (op)
      1: return w;
      2: return o | w;
      3: return o & ~w;
      default: return o;
    endcase
  endfunction

  // m = 0 for the XLEN=64 instance, 1 for XLEN=32
  function automatic bit decode(int m, int op, logic [11:0] adr, output bit is_inh,
                                output bit hi, output int idx);
    bit impl, page_ok;
    is_inh = (adr == 12'h320);
    hi     = adr[7];
    idx    = int'(adr[4:0]);
    if (is_inh) return 1'b1;
    impl    = (idx == 0) || (idx == 2) || (idx >= 3 && idx < 3 + NH);
    page_ok = (adr[11:8] == 4'hB) || (SHADOW && adr[11:8] == 4'hC && op == 0);
    return page_ok && (adr[6:5] == 2'b00) && impl && (!hi || m == 1);
  endfunction

  function automatic logic [63:0] half(int m, logic [63:0] c, bit hi);
    if (m == 0) return c;
    return hi ? (c >> 32) : (c & 64'hFFFF_FFFF);
  endfunction

  function automatic logic [63:0] inc_of(int idx, logic [IW-1:0] r, logic [NH*IW-1:0] h);
    if (idx == 0) return 64'd1;
    if (idx == 2) return 64'(r);
    return 64'(h[(idx-3)*IW +: IW]);
  endfunction

  function automatic exp_t predict(int m, bit en, int op, logic [11:0] adr);
    exp_t e;
    bit is_inh, hi, lg;
    int t;
    e.rd  = 64'd0;
    e.ill = 1'b0;
    if (!en) return e;
    lg = decode(m, op, adr, is_inh, hi, t);
    if (!lg) begin
      e.ill = 1'b1;
      return e;
    end
    e.rd = is_inh ? minh[m] : half(m, mcnt[m][t], hi);
    return e;
  endfunction

  task automatic model_edge(int m, bit rst, bit en, int op, logic [11:0] adr,
                            logic [63:0] wd, logic [IW-1:0] r, logic [NH*IW-1:0] h);
    bit is_inh, hi, lg, wr;
    int t;
    logic [63:0] w, old_inh, hv, c;
    if (!rst) begin
      for (int i = 0; i < 32; i++) mcnt[m][i] = 64'd0;
      minh[m] = 64'd0;
    end else begin
      lg      = decode(m, op, adr, is_inh, hi, t);
      wr      = en && lg && (op != 0);
      w       = (m == 1) ? {32'd0, wd[31:0]} : wd;
      old_inh = minh[m];
      for (int i = 0; i < 3 + NH; i++) begin
        if (i != 1) begin
          c = mcnt[m][i];
          if (wr && !is_inh && t == i) begin
            hv = opf(op, half(m, c, hi), w);
            if (m == 0) c = hv;
            else if (hi) c = {hv[31:0], c[31:0]};
            else c = {c[63:32], hv[31:0]};
          end else if (!old_inh[i]) begin
            c = c + inc_of(i, r, h);
          end
          mcnt[m][i] = c;
        end
      end
      if (wr && is_inh) minh[m] = opf(op, old_inh, w) & INH_MASK;
    end
  endtask

  task automatic cyc(bit rst, bit en, int op, logic [11:0] adr, logic [63:0] wd,
                     logic [IW-1:0] r, logic [NH*IW-1:0] h);
    reset = rst;
    ret   = r;
    hpm   = h;
    b64.CSREn = en; b64.CSROp = csrOp'(op); b64.CSRAdr = adr; b64.WriteData = wd;
    b32.CSREn = en; b32.CSROp = csrOp'(op); b32.CSRAdr = adr; b32.WriteData = wd[31:0];
    q64.push_back(predict(0, en, op, adr));
    q32.push_back(predict(1, en, op, adr));
    @(posedge clk);
    model_edge(0, rst, en, op, adr, wd, r, h);
    model_edge(1, rst, en, op, adr, wd, r, h);
    #1;
  endtask

  task automatic cmp(string nm, exp_t e, logic [63:0] rd, logic ill);
    checks++;
    if (rd !== e.rd || ill !== e.ill) begin
      errors++;
      $display("FAIL %s @%0t adr=%h op=%0d: got ReadData=%h Illegal=%b, expected ReadData=%h Illegal=%b",
               nm, $time, b64.CSRAdr, b64.CSROp, rd, ill, e.rd, e.ill);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (running) begin
      if (q64.size() == 0 || q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got queue sizes %0d/%0d, expected nonzero",
                 q64.size(), q32.size());
      end else begin
        e = q64.pop_front();
        cmp("xlen64", e, b64.ReadData, b64.IllegalAccess);
        e = q32.pop_front();
        cmp("xlen32", e, {32'd0, b32.ReadData}, b32.IllegalAccess);
      end
    end
  end

  logic [11:0] adr_tbl [20] = '{12'h320, 12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB04,
                                12'hB05, 12'hB06, 12'hB07, 12'hB80, 12'hB82, 12'hB83,
                                12'hB86, 12'hB87, 12'hC00, 12'hC02, 12'hC83, 12'h300,
                                12'hB20, 12'hB00};

  initial begin
    logic [63:0] wd;
    int op;
    checks  = 0;
    errors  = 0;
    running = 1'b0;
    reset   = 1'b0;
    ret     = '0;
    hpm     = '0;
    b64.CSREn = 1'b0; b64.CSROp = CSR_READ; b64.CSRAdr = 12'h0; b64.WriteData = '0;
    b32.CSREn = 1'b0; b32.CSROp = CSR_READ; b32.CSRAdr = 12'h0; b32.WriteData = '0;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 32; i++) mcnt[m][i] = 64'd0;
      minh[m] = 64'd0;
    end
    @(posedge clk);
    #1;
    running = 1'b1;

    // reset, idle 10 cycles, read mcycle (10) and minstret (0)
    cyc(1'b0, 1'b0, 0, 12'h000, 64'd0, 2'd0, 8'h00);
    cyc(1'b0, 1'b1, 0, 12'hB00, 64'd0, 2'd0, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 0, 12'h000, 64'd0, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'hB00, 64'd0, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'hB02, 64'd0, 2'd0, 8'h00);

    // low-half write of all ones, then carry into the high half
    cyc(1'b1, 1'b1, 1, 12'hB00, 64'hFFFF_FFFF, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'hB80, 64'd0, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'hB80, 64'd0, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'hB00, 64'd0, 2'd0, 8'h00);

    // write beats same-cycle increment
    cyc(1'b1, 1'b1, 1, 12'hB02, 64'h100, 2'd2, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'hB02, 64'd0, 2'd2, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'hB02, 64'd0, 2'd0, 8'h00);

    // inhibit mhpmcounter3, hold 5 cycles, then release
    cyc(1'b1, 1'b1, 2, 12'h320, 64'h8, 2'd0, 8'h01);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 0, 12'hB03, 64'd0, 2'd0, 8'h01);
    cyc(1'b1, 1'b1, 0, 12'h320, 64'd0, 2'd0, 8'h01);
    cyc(1'b1, 1'b1, 3, 12'h320, 64'h8, 2'd0, 8'h01);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 0, 12'hB03, 64'd0, 2'd0, 8'h01);
    cyc(1'b1, 1'b1, 1, 12'h320, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'h320, 64'd0, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 1, 12'h320, 64'd0, 2'd0, 8'h00);

    // unimplemented HPM and user shadows
    cyc(1'b1, 1'b1, 1, 12'hB07, 64'h55, 2'd1, 8'h55);
    cyc(1'b1, 1'b1, 0, 12'hB07, 64'd0, 2'd1, 8'h55);
    cyc(1'b1, 1'b1, 1, 12'hC00, 64'h77, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'hC00, 64'd0, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 0, 12'hB00, 64'd0, 2'd0, 8'h00);

    // wrap of mhpmcounter3 from all ones
    cyc(1'b1, 1'b1, 1, 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 8'h01);
    cyc(1'b1, 1'b1, 1, 12'hB83, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 8'h01);
    cyc(1'b1, 1'b1, 0, 12'hB03, 64'd0, 2'd0, 8'h01);
    cyc(1'b1, 1'b1, 0, 12'hB03, 64'd0, 2'd0, 8'h01);
    cyc(1'b1, 1'b1, 0, 12'hB83, 64'd0, 2'd0, 8'h01);

    // reset overrides a pending write
    cyc(1'b0, 1'b1, 1, 12'hB00, 64'h1234, 2'd3, 8'hFF);
    cyc(1'b1, 1'b1, 0, 12'hB00, 64'd0, 2'd3, 8'hFF);
    cyc(1'b1, 1'b1, 0, 12'hB06, 64'd0, 2'd3, 8'hFF);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      op = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      case ($urandom_range(0, 3))
        0:       wd = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       wd = 64'(($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 7));
        default: wd = {$urandom(), $urandom()};
      endcase
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 7), op,
          ($urandom_range(0, 9) == 0) ? 12'($urandom()) : adr_tbl[$urandom_range(0, 19)],
          wd, 2'($urandom()), 8'($urandom()));
    end

    running = 1'b0;
    @(negedge clk);
    checks++;
    if (q64.size() != 0 || q32.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0",
               q64.size(), q32.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
